// File: rtl/cpu0_pkg.sv
// Shared cpu0 constants: datapath widths, ISA opcodes and the feeder state encoding.
package cpu0_pkg;

  localparam int PC_W    = 13;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_HALT,
    ST_DONE,
    ST_ERR
  } feeder_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/cpu0_pc_checker.sv
// Delays each issued instruction's expected PC by two cycles to line it up with the
// host's registered pc_out, and latches any disagreement until reset.
module cpu0_pc_checker
  import cpu0_pkg::*;
(
  input  logic            clk,
  input  logic            pon_rst_n_i,
  input  logic            push_i,
  input  logic [PC_W-1:0] exp_pc_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            mismatch_o
);

  logic            s1_vld_q, s2_vld_q;
  logic [PC_W-1:0] s1_pc_q, s2_pc_q;
  logic            mismatch_q;

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s1_pc_q    <= '0;
      s2_pc_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      s1_vld_q <= push_i;
      s1_pc_q  <= exp_pc_i;
      s2_vld_q <= s1_vld_q;
      s2_pc_q  <= s1_pc_q;
      if (s2_vld_q && (s2_pc_q != pc_i)) mismatch_q <= 1'b1;
    end
  end

  assign mismatch_o = mismatch_q;

endmodule

// File: rtl/cpu0_instr_feeder.sv
// Loadable program store that issues one cpu0 instruction per enabled cycle, follows
// the program flow with a shadow PC and cross-checks the host's PC.
module cpu0_instr_feeder
  import cpu0_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  pon_rst_n_i,
  input  logic                  ld_valid_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [INSTR_W-1:0]    ld_data_i,
  output logic                  ld_ready_o,
  input  logic                  start_i,
  input  logic                  issue_en_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic                  halt_i,
  output logic [INSTR_W-1:0]    instruction_o,
  output logic                  instr_valid_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  pc_mismatch_o,
  output logic [CNT_W-1:0]      issued_cnt_o
);

  logic [INSTR_W-1:0] mem [2**DEPTH_LOG2];

  feeder_state_e      state_q;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q, done_q, err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [INSTR_W-1:0] fetch_word;
  logic               pc_in_range;

  // Store is deliberately not reset so a program survives pon_rst_n_i.
  always_ff @(posedge clk) begin
    if (ld_valid_i && (state_q == ST_IDLE)) mem[ld_addr_i] <= ld_data_i;
  end

  assign pc_in_range = ~|pc_q[PC_W-1:DEPTH_LOG2];
  assign fetch_word  = mem[pc_q[DEPTH_LOG2-1:0]];

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (opcode_of(fetch_word) == OP_JMP)       pc_d = fetch_word[PC_W-1:0];
    else if (opcode_of(fetch_word) == OP_HALT) pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
          end
        end
        ST_RUN: begin
          if (!pc_in_range) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else if (issue_en_i) begin
            instr_q <= fetch_word;
            valid_q <= 1'b1;
            pc_q    <= pc_d;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (opcode_of(fetch_word) == OP_HALT) state_q <= ST_WAIT_HALT;
          end
        end
        ST_WAIT_HALT: begin
          if (halt_i) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // While valid_q is high, pc_q already holds that instruction's successor PC.
  cpu0_pc_checker u_pc_checker (
    .clk         (clk),
    .pon_rst_n_i (pon_rst_n_i),
    .push_i      (valid_q),
    .exp_pc_i    (pc_q),
    .pc_i        (pc_i),
    .mismatch_o  (pc_mismatch_o)
  );

  assign ld_ready_o    = (state_q == ST_IDLE);
  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign issued_cnt_o  = cnt_q;

endmodule

// File: doc/cpu0_instr_feeder.md
# cpu0_instr_feeder

Instruction-side counterpart of the cpu0 host. It holds a small loadable program store and issues one 16-bit instruction per cycle on the host's `instruction`/`instr_valid` pair. It tracks a shadow PC by decoding the cpu0 ISA it sends (NOP/ADD/SUB/LOAD/JUMP/HALT). It cross-checks the host's registered `pc_out` against that shadow PC and flags any divergence. It sits between the test/boot loader and the cpu0 host.

## Interface
- `DEPTH_LOG2`, 6: program store has 2^DEPTH_LOG2 words of 16 bits.
- `CNT_W`, 16: width of the issued-instruction counter.
- `clk` in 1: clock, rising edge.
- `pon_rst_n_i` in 1: reset, asynchronous, active-low.
- `ld_valid_i` in 1: program-store write strobe.
- `ld_addr_i` in DEPTH_LOG2: write address.
- `ld_data_i` in 16: write data.
- `ld_ready_o` out 1: store writable, i.e. state IDLE (combinational from state).
- `start_i` in 1: begin issuing from PC 0.
- `issue_en_i` in 1: throttle; issue only when high.
- `pc_i` in 13: host `pc_out`.
- `halt_i` in 1: host `cpu_halt`.
- `instruction_o` out 16: instruction to host.
- `instr_valid_o` out 1: instruction valid, one cycle per instruction.
- `done_o` out 1: HALT issued and `halt_i` seen.
- `err_o` out 1: shadow PC out of store range.
- `pc_mismatch_o` out 1: sticky, `pc_i` differed from expected PC.
- `issued_cnt_o` out CNT_W: instructions issued, saturating.

## Operation
- **States:** IDLE, RUN, WAIT_HALT, DONE, ERR.
- **IDLE:** `ld_valid_i` writes `mem[ld_addr_i]`. `start_i` moves to RUN with shadow PC = 0. `start_i` is ignored in every other state. A write and `start_i` in the same cycle: the write lands before the first fetch.
- **Writes outside IDLE** are dropped. `ld_ready_o` is 0.
- **RUN, `issue_en_i`=1, shadow PC < 2^DEPTH_LOG2:**
  - Register `instruction_o <= mem[pc]` and set `instr_valid_o` to 1.
  - Increment `issued_cnt_o`, saturating at all-ones.
  - Next shadow PC:
    - opcode 4'h4 (JUMP): `instr[12:0]`
    - opcode 4'hF (HALT): unchanged, and the state moves to WAIT_HALT
    - all other opcodes: PC+1, 13-bit wrap
- **RUN, `issue_en_i`=0:** `instr_valid_o`=0 and shadow PC holds.
- **RUN, shadow PC ≥ 2^DEPTH_LOG2** (any bit of [12:DEPTH_LOG2] set): no issue, move to ERR, `err_o`=1.
- **WAIT_HALT:** no issue. Move to DONE on `halt_i`=1.
- **DONE and ERR** are terminal until reset. ERR never asserts `done_o`.
- **PC checker:**
  - Each issued instruction pushes its post-instruction expected PC into a 2-stage delay line.
  - When the stage-2 valid bit is set, compare against `pc_i`. Any inequality sets `pc_mismatch_o`, which stays set until reset.
  - HALT pushes the unchanged PC.
- **Program store:** not reset; contents survive `pon_rst_n_i`.

## Timing
- **Reset values:** state IDLE, `ld_ready_o`=1, and 0 for `instruction_o`, `instr_valid_o`, `done_o`, `err_o`, `pc_mismatch_o`, `issued_cnt_o`, shadow PC and the delay line.
- **Start:** `start_i` sampled at edge k gives RUN after k. The first `instr_valid_o` is high in the cycle after edge k+1, provided `issue_en_i` was high before k+1.
- **Issue rate:** one instruction per cycle. There is no backpressure; the host accepts every valid cycle.
- **Check latency:** an instruction valid in cycle T makes host `program_counter` valid in T+1 and `pc_out` valid in T+2. The compare happens at the edge ending T+2, so `pc_mismatch_o` is visible in T+3.
- **`done_o`:** high in the cycle after the edge sampling `halt_i`=1 in WAIT_HALT.
- **`err_o`:** high the cycle after RUN detects an out-of-range PC.
- **Reset mid-run:** asynchronous return to IDLE. All outputs clear immediately and the delay line clears.

## Structure
- **Package `cpu0_pkg`:**
  - `PC_W`=13, `INSTR_W`=16.
  - Opcode constants `OP_NOP`=4'h0, `OP_ADD`=4'h1, `OP_SUB`=4'h2, `OP_LDI`=4'h3, `OP_JMP`=4'h4, `OP_HALT`=4'hF.
  - Feeder state enum.
- **Sub-module `cpu0_pc_checker`:** 2-stage expected-PC delay line plus comparator and sticky flag.
- **Top level:** store, FSM, shadow PC and counter.

## Test plan
- **Basic program:**
  - Stimulus: load `mem[0]`=16'h3005, `mem[1]`=16'hF000; pulse `start_i` with `issue_en_i`=1, `halt_i` driven by the host.
  - Response: 16'h3005 then 16'hF000 on consecutive valid cycles; `issued_cnt_o`=2; `done_o`=1; `pc_mismatch_o`=0.
- **Jump:**
  - Stimulus: `mem[0]`=16'h4005, `mem[5]`=16'hF000.
  - Response: issues 16'h4005 then 16'hF000; the checker expects PC 5 then 5; no mismatch.
- **Out of range** (`DEPTH_LOG2`=6):
  - Stimulus: `mem[0]`=16'h4040.
  - Response: one issue; next cycle `err_o`=1; `instr_valid_o` stays 0; `done_o`=0.
- **PC mismatch:**
  - Stimulus: force `pc_i`=13'h1FFF while issuing a NOP at T.
  - Response: `pc_mismatch_o`=1 from T+3 and held to the end of the run.
- **Throttle:**
  - Stimulus: `issue_en_i` toggling 1,0,0,1 over four NOPs.
  - Response: valid only on the enabled cycles; shadow PC holds across the gaps; `issued_cnt_o` = number of enabled cycles.
- **Reset mid-run:**
  - Stimulus: assert `pon_rst_n_i` low during RUN.
  - Response: outputs zero at once and `ld_ready_o`=1; the store is intact, so a restart reproduces the identical sequence.
